// File: rtl/rx_fe_pkg.sv
// Shared helpers for rx_adc_frontend: floor shift, signed saturation, constant clog2, DC-block constants.
package rx_fe_pkg;

  localparam int DC_SHIFT = 8;
  localparam int DC_FRAC  = 8;

  function automatic int clog2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Negative amounts become a left shift so gain settings beyond the width margin stay defined.
  function automatic logic signed [31:0] shr_floor(input logic signed [31:0] x, input int amt);
    if (amt >= 0) return x >>> amt;
    return x <<< (-amt);
  endfunction

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/rx_fe_fifo.sv
// Synchronous symbol FIFO; a write while full is accepted only together with a read.
// Head data reads as zero while empty.
module rx_fe_fifo
  import rx_fe_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2c(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rd_ok;
  logic          wr_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_adc_frontend.sv
// Per-channel scale/saturate, moving average, symbol decimation and output FIFO; in_valid to out_valid 3 cycles.
// valid/ready output, full FIFO drops pushes and flags overflow; RX_FE_DC_BLOCK_EN adds a DC-removal stage (+1 cycle).
module rx_adc_frontend
  import rx_fe_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int IN_W       = 14,
  parameter int OUT_W      = 12,
  parameter int AVG_LOG2   = 2,
  parameter int SPS        = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NCH*IN_W-1:0]      in_data,
  input  logic                     enable,
  input  logic [1:0]               shift,
  input  logic [clog2c(SPS)-1:0]   phase,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*OUT_W-1:0]     out_data,
  output logic [15:0]              out_symcnt,
  output logic [NCH-1:0]           sat_flag,
  output logic                     overflow
);

  localparam int PH_W  = clog2c(SPS);
  localparam int SH0   = IN_W - OUT_W;
  localparam int SUM_W = OUT_W + AVG_LOG2;
  localparam int HIST  = 1 << AVG_LOG2;
  localparam int DW    = NCH * OUT_W;

  logic           s_vld;
  logic           y_vld;
  logic           f_vld;
  logic [DW-1:0]  f_dat;
  logic [NCH-1:0] sat_now;

  always_ff @(posedge clk) begin
    if (rst)         s_vld <= 1'b0;
    else if (enable) s_vld <= in_valid;
  end

`ifdef RX_FE_DC_BLOCK_EN
  logic d_vld;

  always_ff @(posedge clk) begin
    if (rst)         d_vld <= 1'b0;
    else if (enable) d_vld <= s_vld;
  end
  assign y_vld = d_vld;
`else
  assign y_vld = s_vld;
`endif

  if (AVG_LOG2 > 0) begin : g_fvld
    always_ff @(posedge clk) begin
      if (rst)         f_vld <= 1'b0;
      else if (enable) f_vld <= y_vld;
    end
  end else begin : g_fvld_byp
    assign f_vld = y_vld;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic signed [IN_W-1:0]  x;
    logic signed [31:0]      s_wide;
    logic signed [31:0]      s_clip;
    logic signed [OUT_W-1:0] s_q;
    logic signed [OUT_W-1:0] y;
    logic                    s_sat;
    logic                    y_sat;

    assign x      = in_data[ch*IN_W +: IN_W];
    assign s_wide = shr_floor(32'(x), SH0 - int'(shift));
    assign s_clip = sat_signed(s_wide, OUT_W);
    assign s_sat  = enable && in_valid && (s_wide != s_clip);

    always_ff @(posedge clk) begin
      if (rst)                     s_q <= '0;
      else if (enable && in_valid) s_q <= s_clip[OUT_W-1:0];
    end

`ifdef RX_FE_DC_BLOCK_EN
    // dc_acc carries DC_FRAC fractional bits; headroom covers the full signed sample range.
    localparam int ACC_W = OUT_W + DC_FRAC + 2;

    logic signed [ACC_W-1:0] dc_acc;
    logic signed [31:0]      dc_int;
    logic signed [31:0]      dc_step;
    logic signed [31:0]      d_wide;
    logic signed [31:0]      d_clip;
    logic signed [OUT_W-1:0] d_q;

    assign dc_int  = 32'(dc_acc >>> DC_FRAC);
    assign dc_step = ((32'(s_q) <<< DC_FRAC) - 32'(dc_acc)) >>> DC_SHIFT;
    assign d_wide  = 32'(s_q) - dc_int;
    assign d_clip  = sat_signed(d_wide, OUT_W);
    assign y_sat   = enable && s_vld && (d_wide != d_clip);
    assign y       = d_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dc_acc <= '0;
        d_q    <= '0;
      end else if (enable && s_vld) begin
        dc_acc <= dc_acc + ACC_W'(dc_step);
        d_q    <= d_clip[OUT_W-1:0];
      end
    end
`else
    assign y_sat = 1'b0;
    assign y     = s_q;
`endif

    assign sat_now[ch] = s_sat | y_sat;

    if (AVG_LOG2 > 0) begin : g_avg
      logic signed [OUT_W-1:0] hist [HIST];
      logic signed [SUM_W-1:0] sum;

      // Running sum over the last HIST samples: add newest, drop the one leaving the window.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum <= '0;
          for (int i = 0; i < HIST; i++) hist[i] <= '0;
        end else if (enable && y_vld) begin
          sum     <= sum + SUM_W'(y) - SUM_W'(hist[HIST-1]);
          hist[0] <= y;
          for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
        end
      end

      assign f_dat[ch*OUT_W +: OUT_W] = OUT_W'(sum >>> AVG_LOG2);
    end else begin : g_byp
      assign f_dat[ch*OUT_W +: OUT_W] = y;
    end
  end

  logic [PH_W-1:0] cnt;
  logic [PH_W-1:0] ph_q;
  logic            push;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic            empty;

  assign push    = enable && f_vld && (cnt == ph_q);
  assign pop     = out_valid && out_ready;
  assign push_ok = push && (!full || pop);

  // Phase changes only take effect at a symbol boundary so a window is never sampled twice or skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      ph_q <= '0;
    end else if (enable && f_vld) begin
      if (cnt == PH_W'(SPS - 1)) begin
        cnt  <= '0;
        ph_q <= phase;
      end else begin
        cnt <= cnt + PH_W'(1);
      end
    end
  end

  rx_fe_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (f_dat),
    .rd_en   (pop),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_symcnt <= '0;
      sat_flag   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)          out_symcnt <= out_symcnt + 16'd1;
      if (push && !push_ok) overflow   <= 1'b1;
      sat_flag <= sat_flag | sat_now;
    end
  end

endmodule

// File: tb/tb_rx_adc_frontend.sv
// Directed bench for rx_adc_frontend at default parameters (2 ch, 14->12 bit, 4-tap average, 8 sps, depth 16).
module tb_rx_adc_frontend;

  localparam int NCH        = 2;
  localparam int IN_W       = 14;
  localparam int OUT_W      = 12;
  localparam int AVG_LOG2   = 2;
  localparam int SPS        = 8;
  localparam int FIFO_DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [NCH*IN_W-1:0]  in_data;
  logic                 enable;
  logic [1:0]           shift;
  logic [2:0]           phase;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*OUT_W-1:0] out_data;
  logic [15:0]          out_symcnt;
  logic [NCH-1:0]       sat_flag;
  logic                 overflow;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] got[$];

  int scl_exp[6] = '{511, 2047, 1023, -2048, -1025, 2047};
  int dec_idx[8] = '{0, 11, 19, 27, 35, 46, 54, 62};

  always #5 clk = ~clk;

  rx_adc_frontend #(
    .NCH        (NCH),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .AVG_LOG2   (AVG_LOG2),
    .SPS        (SPS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .enable     (enable),
    .shift      (shift),
    .phase      (phase),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_symcnt (out_symcnt),
    .sat_flag   (sat_flag),
    .overflow   (overflow)
  );

  // Record every symbol the consumer takes; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] sym(input int a, input int b);
    logic [11:0] la;
    logic [11:0] lb;
    la = 12'(a);
    lb = 12'(b);
    return {lb, la};
  endfunction

  // 4-tap floor average of the scaled ramp k*(j+base), history zero before index 0.
  function automatic int avg_ref(input int n, input int k, input int base);
    int s;
    s = 0;
    for (int j = (n >= 3 ? n - 3 : 0); j <= n; j++) s += k * (j + base);
    return s / 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst      = 1'b1;
    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic feed_ramp(input int start, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      step();
      enable   = 1'b1;
      in_valid = 1'b1;
      shift    = 2'd0;
      in_data  = {14'(8 * (start + i + base)), 14'(4 * (start + i + base))};
    end
  endtask

  task automatic feed_const(input int n, input int v, input logic [1:0] sh);
    for (int i = 0; i < n; i++) begin
      step();
      enable   = 1'b1;
      in_valid = 1'b1;
      shift    = sh;
      in_data  = {14'(v), 14'(v)};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    enable    = 1'b1;
    shift     = 2'd0;
    phase     = 3'd0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_symcnt", out_symcnt, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    got.delete();

    // Scaling and saturation through the averager: blocks of 16 so each step is seen at idx 0/8 of a block.
    feed_const(16, 8191, 2'd0);
    feed_const(16, -8192, 2'd0);
    chk("scl_sat_before", sat_flag, 0);
    feed_const(16, 8191, 2'd2);
    idle(6);
    chk("scl_sat_after", sat_flag, 2'b11);
    chk("scl_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("scl_sym%0d", i), got[i], sym(scl_exp[i], scl_exp[i]));
    chk("scl_symcnt", out_symcnt, 6);

    // Decimation: phase 0 from reset for the first window, then 3, then 6 after a mid-run change.
    do_reset();
    phase = 3'd3;
    feed_ramp(0, 37, 0);
    phase = 3'd6;
    feed_ramp(37, 27, 0);
    idle(6);
    chk("dec_count", got.size(), 8);
    chk("dec_symcnt", out_symcnt, 8);
    for (int i = 0; i < 8; i++)
      if (i < got.size())
        chk($sformatf("dec_sym%0d", i), got[i],
            sym(avg_ref(dec_idx[i], 1, 0), avg_ref(dec_idx[i], 2, 0)));

    // Freeze with a push pending at F; the held sample must come out exactly once.
    do_reset();
    phase = 3'd0;
    feed_ramp(0, 10, 0);
    repeat (10) begin
      step();
      enable   = 1'b0;
      in_valid = 1'b1;
      in_data  = {14'(4000), 14'(2000)};
    end
    chk("en_symcnt_frozen", out_symcnt, 1);
    chk("en_out_valid_frozen", out_valid, 0);
    feed_ramp(10, 22, 0);
    idle(6);
    chk("en_count", got.size(), 4);
    chk("en_symcnt", out_symcnt, 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size())
        chk($sformatf("en_sym%0d", i), got[i], sym(avg_ref(8 * i, 1, 0), avg_ref(8 * i, 2, 0)));

    // Backpressure: 17 pushes into a 16-deep FIFO.
    do_reset();
    out_ready = 1'b0;
    feed_ramp(0, 136, 100);
    idle(6);
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_symcnt", out_symcnt, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_data, sym(25, 50));
    idle(3);
    chk("ovf_head_stable", out_data, sym(25, 50));
    out_ready = 1'b1;
    idle(20);
    chk("ovf_drain_count", got.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < got.size())
        chk($sformatf("ovf_drain%0d", i), got[i],
            sym(avg_ref(8 * i, 1, 100), avg_ref(8 * i, 2, 100)));
    chk("ovf_flag_sticky", overflow, 1);
    chk("ovf_empty", out_valid, 0);

    // Reset with a full FIFO, saturation flagged and samples in flight.
    out_ready = 1'b0;
    feed_const(140, 8191, 2'd2);
    chk("mr_pre_full", out_valid, 1);
    chk("mr_pre_sat", sat_flag, 2'b11);
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_symcnt", out_symcnt, 0);
    chk("mr_sat_flag", sat_flag, 0);
    chk("mr_overflow", overflow, 0);
    got.delete();
    out_ready = 1'b1;
    feed_ramp(0, 8, 100);
    idle(6);
    chk("mr_count", got.size(), 1);
    if (got.size() > 0) chk("mr_first_sym", got[0], sym(25, 50));
    chk("mr_symcnt_after", out_symcnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
